// File: rtl/inst_fetch.sv
// Instruction fetch stage: fetches the word at pc over a req/gnt/rvalid
// handshake and hands it to decode with valid/ready, stalling the PC stage.
module inst_fetch #(
  parameter logic [31:0] NOP_INST = 32'h0000_0013,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc,
  input  logic        flush,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_valid,
  input  logic        id_ready,
  output logic [1:0]  fetch_err,
  output logic        stall
);

  localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

  localparam logic [1:0] ERR_OK    = 2'b00;
  localparam logic [1:0] ERR_ALIGN = 2'b01;
  localparam logic [1:0] ERR_TMO   = 2'b10;

  typedef enum logic [2:0] {IDLE, REQ, WAIT, VALID, DRAIN} state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      fetch_addr;
  logic             aligned;
  logic             timed_out;

  assign aligned   = (pc[1:0] == 2'b00);
  assign timed_out = (cnt == CNT_MAX);
  assign imem_addr = pc;
  assign imem_req  = (state == REQ) && aligned;
  assign stall     = !((state == VALID) && id_ready && !flush);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  state_next = REQ;
      REQ: begin
        if (aligned && imem_gnt)  state_next = flush ? DRAIN : WAIT;
        else if (!aligned && !flush) state_next = VALID;
      end
      WAIT: begin
        if (flush)                          state_next = imem_rvalid ? REQ : DRAIN;
        else if (imem_rvalid || timed_out)  state_next = VALID;
      end
      VALID: if (flush || id_ready) state_next = REQ;
      // A flush here changes nothing: the outstanding response still has to be absorbed.
      DRAIN: if (imem_rvalid || timed_out) state_next = REQ;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Cleared while requesting; keeps running across WAIT->DRAIN so a flush
  // never extends the overall wait for a lost response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                          cnt <= '0;
    else if (state == REQ)                               cnt <= '0;
    else if ((state == WAIT || state == DRAIN) && !timed_out) cnt <= cnt + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inst       <= NOP_INST;
      inst_pc    <= '0;
      fetch_err  <= ERR_OK;
      fetch_addr <= '0;
      inst_valid <= 1'b0;
    end else begin
      inst_valid <= (state_next == VALID);
      case (state)
        REQ: begin
          if (aligned) begin
            if (imem_gnt) fetch_addr <= pc;
          end else if (!flush) begin
            inst      <= NOP_INST;
            inst_pc   <= pc;
            fetch_err <= ERR_ALIGN;
          end
        end
        WAIT: begin
          if (!flush) begin
            if (imem_rvalid) begin
              inst      <= imem_rdata;
              inst_pc   <= fetch_addr;
              fetch_err <= ERR_OK;
            end else if (timed_out) begin
              inst      <= NOP_INST;
              inst_pc   <= fetch_addr;
              fetch_err <= ERR_TMO;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed scenarios plus a randomized run against a
// transaction-level memory/PC model.
`timescale 1ns/1ps
module tb_inst_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int          TMO = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pc = 32'h0;
  logic        flush = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        id_ready = 1'b0;
  logic [1:0]  fetch_err;
  logic        stall;

  int n_cmp = 0;
  int n_bad = 0;

  inst_fetch #(.NOP_INST(NOP), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .flush(flush),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .inst(inst), .inst_pc(inst_pc), .inst_valid(inst_valid),
    .id_ready(id_ready), .fetch_err(fetch_err), .stall(stall)
  );

  always #5 clk = ~clk;

  // Memory responder configuration
  int          cfg_gnt = 0;
  int          cfg_rv = 0;
  bit          cfg_rand = 1'b0;
  bit          cfg_mute = 1'b0;
  bit          cfg_force = 1'b0;
  logic [31:0] cfg_force_data = 32'h0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  function automatic logic [31:0] rand_target();
    logic [31:0] t;
    t = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
    if ($urandom_range(0, 7) == 0) t[1:0] = 2'($urandom_range(1, 3));
    return t;
  endfunction

  // Memory with configurable grant and response latency, one transaction at a time.
  initial begin : responder
    bit          pend;
    int          g_wait;
    int          rv_wait;
    logic [31:0] resp_data;
    pend = 1'b0; g_wait = 0; rv_wait = 0; resp_data = 32'h0;
    forever begin
      @(negedge clk);
      imem_gnt = 1'b0;
      imem_rvalid = 1'b0;
      if (!rst_n) begin
        pend = 1'b0;
        g_wait = cfg_gnt;
      end else if (pend) begin
        if (rv_wait == 0) begin
          pend = 1'b0;
          if (!cfg_mute) begin
            imem_rvalid = 1'b1;
            imem_rdata = resp_data;
          end
        end else rv_wait--;
      end else if (imem_req !== 1'b1) begin
        g_wait = cfg_rand ? int'($urandom_range(0, 3)) : cfg_gnt;
      end else if (g_wait == 0) begin
        imem_gnt = 1'b1;
        pend = 1'b1;
        resp_data = cfg_force ? cfg_force_data : mem_word(imem_addr);
        rv_wait = cfg_rand ? int'($urandom_range(0, 3)) : cfg_rv;
        g_wait = cfg_rand ? int'($urandom_range(0, 3)) : cfg_gnt;
      end else g_wait--;
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic do_reset();
    rst_n = 1'b0; flush = 1'b0; id_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pc = 32'h0; id_ready = 1'b0; flush = 1'b0;
    cfg_gnt = 0; cfg_rv = 0; cfg_rand = 1'b0; cfg_mute = 1'b0; cfg_force = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++; if (inst !== NOP) begin n_bad++; $display("FAIL rst_inst: got %h expected %h", inst, NOP); end
      n_cmp++; if (inst_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b expected 0", inst_valid); end
      n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL rst_req: got %b expected 0", imem_req); end
      n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL rst_stall: got %b expected 1", stall); end
      n_cmp++; if (fetch_err !== 2'b00 || inst_pc !== 32'h0) begin
        n_bad++; $display("FAIL rst_err_pc: got %b/%h expected 00/0", fetch_err, inst_pc);
      end
    end
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL idle_req: got %b expected 0", imem_req); end
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL idle_stall: got %b expected 1", stall); end
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      n_bad++; $display("FAIL first_req: got req=%b addr=%h expected req=1 addr=0", imem_req, imem_addr);
    end
  endtask

  task automatic test_zero_wait();
    bit          exp_v;
    logic [31:0] exp_pc;
    cfg_gnt = 0; cfg_rv = 0; cfg_rand = 1'b0; cfg_mute = 1'b0; cfg_force = 1'b0;
    pc = 32'h0;
    do_reset();
    id_ready = 1'b1;
    for (int c = 0; c <= 10; c++) begin
      @(negedge clk);
      exp_v = (c >= 3) && (c % 3 == 0);
      n_cmp++; if (inst_valid !== exp_v) begin n_bad++; $display("FAIL zw_valid c=%0d: got %b expected %b", c, inst_valid, exp_v); end
      if (exp_v) begin
        exp_pc = 32'(4 * (c / 3 - 1));
        n_cmp++; if (inst_pc !== exp_pc) begin n_bad++; $display("FAIL zw_pc c=%0d: got %h expected %h", c, inst_pc, exp_pc); end
        n_cmp++; if (inst !== mem_word(exp_pc)) begin n_bad++; $display("FAIL zw_inst c=%0d: got %h expected %h", c, inst, mem_word(exp_pc)); end
        n_cmp++; if (fetch_err !== 2'b00) begin n_bad++; $display("FAIL zw_err c=%0d: got %b expected 00", c, fetch_err); end
      end
      @(posedge clk); #1;
      if (exp_v) pc = pc + 32'd4;
    end
  endtask

  task automatic test_backpressure();
    bit exp_v;
    cfg_gnt = 3; cfg_rv = 2; cfg_rand = 1'b0; cfg_mute = 1'b0; cfg_force = 1'b0;
    pc = 32'h20;
    do_reset();
    for (int c = 0; c <= 13; c++) begin
      id_ready = (c >= 12);
      @(negedge clk);
      exp_v = (c >= 8) && (c <= 12);
      n_cmp++; if (inst_valid !== exp_v) begin n_bad++; $display("FAIL bp_valid c=%0d: got %b expected %b", c, inst_valid, exp_v); end
      n_cmp++; if (stall !== (c != 12)) begin n_bad++; $display("FAIL bp_stall c=%0d: got %b expected %b", c, stall, c != 12); end
      if (c >= 1 && c <= 4) begin
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h20) begin
          n_bad++; $display("FAIL bp_req c=%0d: got req=%b addr=%h expected req=1 addr=20", c, imem_req, imem_addr);
        end
      end
      if (exp_v) begin
        n_cmp++; if (inst !== mem_word(32'h20) || inst_pc !== 32'h20 || fetch_err !== 2'b00) begin
          n_bad++; $display("FAIL bp_hold c=%0d: got %h@%h err %b expected %h@20 err 00", c, inst, inst_pc, fetch_err, mem_word(32'h20));
        end
      end
      if (c == 13) begin
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h24) begin
          n_bad++; $display("FAIL bp_next: got req=%b addr=%h expected req=1 addr=24", imem_req, imem_addr);
        end
      end
      @(posedge clk); #1;
      if (c == 12) pc = 32'h24;
    end
    id_ready = 1'b0;
  endtask

  task automatic test_flush();
    cfg_gnt = 0; cfg_rv = 2; cfg_rand = 1'b0; cfg_mute = 1'b0;
    cfg_force = 1'b1; cfg_force_data = 32'hDEAD_BEEF;
    pc = 32'h40;
    do_reset();
    for (int c = 0; c <= 8; c++) begin
      flush = (c == 2);
      @(negedge clk);
      if (c <= 6) begin
        n_cmp++; if (inst_valid !== 1'b0) begin n_bad++; $display("FAIL fl_valid c=%0d: got %b expected 0", c, inst_valid); end
      end
      if (c >= 2 && c <= 6) begin
        n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL fl_stall c=%0d: got %b expected 1", c, stall); end
      end
      if (c == 3 || c == 4) begin
        n_cmp++; if (imem_req !== 1'b0 || inst !== NOP) begin
          n_bad++; $display("FAIL fl_drain c=%0d: got req=%b inst=%h expected req=0 inst=%h", c, imem_req, inst, NOP);
        end
      end
      if (c == 5) begin
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
          n_bad++; $display("FAIL fl_newreq: got req=%b addr=%h expected req=1 addr=100", imem_req, imem_addr);
        end
      end
      if (c == 7) begin
        n_cmp++; if (inst_valid !== 1'b1 || inst !== mem_word(32'h100) || inst_pc !== 32'h100) begin
          n_bad++; $display("FAIL fl_result: got v=%b %h@%h expected v=1 %h@100", inst_valid, inst, inst_pc, mem_word(32'h100));
        end
      end
      @(posedge clk); #1;
      if (c == 2) begin
        pc = 32'h100; flush = 1'b0; cfg_force = 1'b0; cfg_rv = 0;
      end
    end
  endtask

  task automatic test_timeout();
    bit exp_v;
    cfg_gnt = 0; cfg_rv = 0; cfg_rand = 1'b0; cfg_mute = 1'b1; cfg_force = 1'b0;
    pc = 32'h80;
    do_reset();
    for (int c = 0; c <= 19; c++) begin
      @(negedge clk);
      exp_v = (c >= 2 + TMO);
      n_cmp++; if (inst_valid !== exp_v) begin n_bad++; $display("FAIL tmo_valid c=%0d: got %b expected %b", c, inst_valid, exp_v); end
      if (c == 2 + TMO) begin
        n_cmp++; if (inst !== NOP || fetch_err !== 2'b10) begin
          n_bad++; $display("FAIL tmo_result: got %h err %b expected %h err 10", inst, fetch_err, NOP);
        end
      end
      @(posedge clk); #1;
    end
    cfg_mute = 1'b0;
  endtask

  task automatic test_misaligned();
    cfg_gnt = 0; cfg_rv = 0; cfg_rand = 1'b0; cfg_mute = 1'b0; cfg_force = 1'b0;
    pc = 32'h6;
    do_reset();
    for (int c = 0; c <= 3; c++) begin
      @(negedge clk);
      n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL mis_req c=%0d: got %b expected 0", c, imem_req); end
      if (c == 1) begin
        n_cmp++; if (inst_valid !== 1'b0) begin n_bad++; $display("FAIL mis_early: got %b expected 0", inst_valid); end
      end
      if (c >= 2) begin
        n_cmp++; if (inst_valid !== 1'b1 || inst_pc !== 32'h6 || fetch_err !== 2'b01 || inst !== NOP) begin
          n_bad++; $display("FAIL mis_result c=%0d: got v=%b %h@%h err %b expected v=1 %h@6 err 01", c, inst_valid, inst, inst_pc, fetch_err, NOP);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_random();
    bit          consume;
    int          idle_run;
    int          consumed;
    logic [31:0] exp_i;
    logic [1:0]  exp_e;
    cfg_rand = 1'b1; cfg_mute = 1'b0; cfg_force = 1'b0;
    pc = rand_target();
    idle_run = 0; consumed = 0;
    do_reset();
    for (int c = 0; c < 800; c++) begin
      id_ready = ($urandom_range(0, 9) < 6);
      flush = ($urandom_range(0, 11) == 0);
      @(negedge clk);
      consume = (inst_valid === 1'b1) && id_ready && !flush;
      n_cmp++; if (stall !== !consume) begin n_bad++; $display("FAIL rnd_stall c=%0d: got %b expected %b", c, stall, !consume); end
      if (inst_valid === 1'b1) begin
        idle_run = 0;
        exp_i = (pc[1:0] != 2'b00) ? NOP : mem_word(pc);
        exp_e = (pc[1:0] != 2'b00) ? 2'b01 : 2'b00;
        n_cmp++; if (inst_pc !== pc) begin n_bad++; $display("FAIL rnd_pc c=%0d: got %h expected %h", c, inst_pc, pc); end
        n_cmp++; if (inst !== exp_i || fetch_err !== exp_e) begin
          n_bad++; $display("FAIL rnd_inst c=%0d: got %h err %b expected %h err %b", c, inst, fetch_err, exp_i, exp_e);
        end
      end else begin
        idle_run++;
        if (idle_run > 150) begin
          n_cmp++; n_bad++;
          $display("FAIL rnd_progress c=%0d: got %0d idle cycles expected at most 150", c, idle_run);
          break;
        end
      end
      if (consume) consumed++;
      @(posedge clk); #1;
      if (flush) pc = rand_target();
      else if (consume) pc = (pc[1:0] != 2'b00 || $urandom_range(0, 3) == 0) ? rand_target() : pc + 32'd4;
    end
    n_cmp++; if (consumed < 30) begin n_bad++; $display("FAIL rnd_count: got %0d consumed expected at least 30", consumed); end
    flush = 1'b0; id_ready = 1'b0; cfg_rand = 1'b0;
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_backpressure();
    test_flush();
    test_timeout();
    test_misaligned();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
